// File: rtl/counter_share_arbiter_pkg.sv
// rtl/counter_share_arbiter_pkg.sv - shared state encodings and default sizes
package counter_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_share_arbiter_counter_core.sv
// rtl/counter_share_arbiter_counter_core.sv - up-counter with sync clear and enable
module counter_core
  import counter_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  // Clear has priority over enable so a grant always starts the interval at zero
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = q_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/counter_share_arbiter.sv
// rtl/counter_share_arbiter.sv - round-robin sharing of one counter among requesters
module counter_share_arbiter
  import counter_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] len_i,
  input  logic                     hold_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [WIDTH-1:0]         q_o,
  output logic [IW-1:0]            active_id_o
);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [WIDTH-1:0]     target_q, target_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;

  logic                 win_found, hi_found;
  logic [IW-1:0]        win_idx, lo_idx, hi_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [WIDTH-1:0]     win_len;
  logic [IW-1:0]        owner, nxt_ptr;
  logic                 req_owner;
  logic                 cnt_clr, cnt_en;
  logic [WIDTH-1:0]     cnt_q;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap)
  always_comb begin
    win_found = 1'b0;
    hi_found  = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_found = 1'b1;
        lo_idx    = IW'(i);
        if (IW'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_idx    = hi_found ? hi_idx : lo_idx;
    win_onehot = '0;
    win_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_onehot[i] = 1'b1;
        win_len       = len_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Owner index from the one-hot grant; zero when nothing is granted
  always_comb begin
    owner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner = IW'(i);
      end
    end
    req_owner = |(req_i & grant_q);
    nxt_ptr   = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  end

  // FSM next state, counter control and grant bookkeeping; abort beats hold
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    target_d = target_q;
    grant_d  = grant_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_COUNT;
          target_d = win_len;
          grant_d  = win_onehot;
          cnt_clr  = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!req_owner) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
          cnt_clr = 1'b1;
        end else if (hold_i) begin
          state_d = ST_COUNT;
        end else if (cnt_q == target_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = nxt_ptr;
        cnt_clr = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // State, pointer, latched terminal count and grant registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      target_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      target_q <= target_d;
      grant_q  <= grant_d;
    end
  end

  counter_core #(
    .WIDTH(WIDTH)
  ) u_counter_core (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .q_o   (cnt_q)
  );

  assign grant_o     = grant_q;
  assign done_o      = (state_q == ST_DONE) ? grant_q : '0;
  assign busy_o      = (state_q != ST_IDLE);
  assign q_o         = cnt_q;
  assign active_id_o = owner;

endmodule

// File: tb/tb_counter_share_arbiter.sv
// tb/tb_counter_share_arbiter.sv - directed scoreboard bench for counter_share_arbiter
module tb_counter_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] len;
  logic        hold;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic [3:0]  q;
  logic [1:0]  aid;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [3:0] d;
    logic       b;
    logic [3:0] q;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];

  counter_share_arbiter dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .len_i      (len),
    .hold_i     (hold),
    .grant_o    (grant),
    .done_o     (done),
    .busy_o     (busy),
    .q_o        (q),
    .active_id_o(aid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
  endtask

  task automatic push(input int g, input int d, input int b, input int qv, input int id);
    exp_t e;
    e.g  = 4'(g);
    e.d  = 4'(d);
    e.b  = 1'(b);
    e.q  = 4'(qv);
    e.id = 2'(id);
    sb.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    chk("grant", {4'b0, grant}, {4'b0, e.g});
    chk("done",  {4'b0, done},  {4'b0, e.d});
    chk("busy",  {7'b0, busy},  {7'b0, e.b});
    chk("q",     {4'b0, q},     {4'b0, e.q});
    chk("active_id", {6'b0, aid}, {6'b0, e.id});
  endtask

  task automatic step(input int g, input int d, input int b, input int qv, input int id);
    push(g, d, b, qv, id);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic now_chk(input int g, input int d, input int b, input int qv, input int id);
    push(g, d, b, qv, id);
    #1;
    compare_front();
  endtask

  // Expected grant interval: Q = 0..len (stretched by hold_n cycles at Q = hold_at), then DONE
  task automatic run_interval(input int ow, input int ln, input int hold_at, input int hold_n);
    int g;
    g = 1 << ow;
    step(g, 0, 1, 0, ow);
    for (int c = 1; c <= ln + 1; c++) begin
      if ((c - 1 == hold_at) && (hold_n > 0)) begin
        hold = 1'b1;
        repeat (hold_n) step(g, 0, 1, c - 1, ow);
        hold = 1'b0;
      end
      if (c <= ln) step(g, 0, 1, c, ow);
      else step(g, g, 1, ln, ow);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    hold  = 1'b0;
    #2;
    now_chk(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // single request, Len = 3
    req = 4'b0001;
    len = 16'h0003;
    run_interval(0, 3, -1, 0);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // round robin between requesters 1 and 3
    req = 4'b1010;
    len = 16'h1111;
    run_interval(1, 1, -1, 0);
    step(0, 0, 0, 0, 0);
    run_interval(3, 1, -1, 0);
    step(0, 0, 0, 0, 0);
    run_interval(1, 1, -1, 0);
    step(0, 0, 0, 0, 0);
    run_interval(3, 1, -1, 0);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // hold for 4 cycles, Len = 15, no wrap
    req = 4'b0100;
    len = 16'h0F00;
    run_interval(2, 15, 5, 4);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // abort at Q = 2 with requester 3 pending
    req = 4'b0100;
    len = 16'h1500;
    step(4, 0, 1, 0, 2);
    req = 4'b1100;
    step(4, 0, 1, 1, 2);
    step(4, 0, 1, 2, 2);
    req = 4'b1000;
    step(0, 0, 0, 0, 0);
    run_interval(3, 1, -1, 0);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // Len changed after grant keeps the latched target
    req = 4'b0001;
    len = 16'h0002;
    step(1, 0, 1, 0, 0);
    len = 16'h0009;
    step(1, 0, 1, 1, 0);
    step(1, 0, 1, 2, 0);
    step(1, 1, 1, 2, 0);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // Len = 0
    req = 4'b0010;
    len = 16'h0000;
    run_interval(1, 0, -1, 0);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    // asynchronous reset mid-count at Q = 5
    req = 4'b0001;
    len = 16'h0009;
    step(1, 0, 1, 0, 0);
    for (int i = 1; i <= 5; i++) step(1, 0, 1, i, 0);
    rst_n = 1'b0;
    now_chk(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    req = 4'b1010;
    rst_n = 1'b1;
    step(2, 0, 1, 0, 1);
    req = 4'b0000;
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/counter_share_arbiter.md
# counter_share_arbiter

Round-robin arbiter that shares one 4-bit up-counter between several requesters. Each requester asks for a timed interval of its own length. The block grants the counter to one requester at a time, clears and enables it, detects terminal count, and pulses a per-requester done flag. It sits between the requesting control blocks and the counter datapath.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, counter width in bits
- Clock  in  1  system clock, rising edge
- Clear  in  1  asynchronous active-low reset
- Req  in  NUM_REQ  per-requester request level; must stay high until Done
- Len  in  NUM_REQ*WIDTH  per-requester terminal count; requester i at [i*WIDTH +: WIDTH]
- Hold  in  1  pauses counting while high (count enable = ~Hold)
- Grant  out  NUM_REQ  one-hot owner of the counter; zero when idle
- Done  out  NUM_REQ  one-hot, one-cycle pulse on interval completion
- Busy  out  1  high whenever state is not IDLE
- Q  out  WIDTH  current counter value
- Active_Id  out  clog2(NUM_REQ)  index of the current owner; 0 when idle

## Operation
- States: IDLE, COUNT, DONE.
- IDLE:
  - If Req != 0 at an edge, pick the first set bit searching upward from pointer ptr, wrapping modulo NUM_REQ.
  - Latch Len of the winner into target, set Grant and Active_Id, clear Q to 0, go to COUNT.
  - If Req == 0, stay in IDLE.
- COUNT, at each edge:
  - If Req[owner] == 0: abort. Go to IDLE, clear Grant, no Done, ptr = owner+1.
  - Else if Hold == 1: hold Q and state.
  - Else if Q == target: go to DONE, Q holds.
  - Else: Q = Q+1.
- DONE:
  - Done[owner] = 1 for exactly this cycle; Grant is still asserted.
  - Next edge: go to IDLE, Grant = 0, Q = 0, ptr = owner+1 mod NUM_REQ.
  - Hold and Req are ignored in DONE.
- Q never wraps, because counting stops at target (max 2^WIDTH-1 = 15).
- Len is sampled only at grant. Changes to Len mid-interval have no effect.
- Requests that arrive during COUNT or DONE wait. They are arbitrated in IDLE on the cycle after DONE.

## Timing
- Reset (Clear low, asynchronous, immediate):
  - state IDLE, ptr 0, target 0.
  - Grant 0, Done 0, Busy 0, Q 0, Active_Id 0.
- Release is synchronous to the next rising edge. Arbitration starts on the first edge with Clear high.
- Grant latency: Req high before edge k means Grant is valid after edge k.
- Interval length with Hold low: Grant is high for Len+2 cycles.
  - Len+1 cycles in COUNT (Q = 0..Len).
  - 1 cycle in DONE.
- Len = 0: one COUNT cycle (Q = 0), then DONE.
- Each Hold-high cycle in COUNT extends the interval by exactly one cycle.
- Back-to-back service: at least one IDLE cycle between successive grants.
- Abort and Hold in the same cycle: abort wins.
- Reset mid-interval clears everything asynchronously. No Done is issued.

## Structure
- Shared package/header holds:
  - State encodings: IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2.
  - Default NUM_REQ and WIDTH.
- Sub-module counter_core: WIDTH-bit up-counter with async active-low Clear, synchronous clear, and enable. The arbiter drives its clear and enable.
- Round-robin search is combinational logic in the top level. The one-hot-to-index conversion produces Active_Id.

## Test plan
- Reset: Clear low mid-COUNT with Q = 5 -> all outputs 0 immediately; first grant after release goes to the lowest set Req bit.
- Single request: Req = 4'b0001, Len[3:0] = 3, Hold = 0 -> Grant = 0001 for 5 cycles, Q = 0,1,2,3,3, Done[0] pulse in the 5th cycle, Busy low afterwards.
- Round-robin: Req = 4'b1010 held, Len = 1 for all -> grant order 1, 3, 1, 3 with one IDLE cycle between grants; Done pulses in the same order.
- Hold: Req = 0100, Len[11:8] = 15, Hold high for 4 cycles mid-count -> Q freezes for 4 cycles, reaches 15 without wrap, Grant lasts 21 cycles.
- Abort: Req[2] dropped at Q = 2 -> next cycle Grant = 0, no Done, a pending Req[3] is granted next.
- Len = 0 and late Len change: Len changed after grant -> the original target is used; Len = 0 -> Grant for 2 cycles, Done on the 2nd.
